// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - Big-endian lane constants: sel[3] is bits 31:24, which is byte addr[1:0]==00
//   - Size and wait-state limits, plus a lane write-enable helper
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    // Single bytes, named by byte offset within the word.
    localparam logic [3:0] SEL_B0 = 4'b1000;
    localparam logic [3:0] SEL_B1 = 4'b0100;
    localparam logic [3:0] SEL_B2 = 4'b0010;
    localparam logic [3:0] SEL_B3 = 4'b0001;
    // Halfwords at offset 0 and offset 2, and the full word.
    localparam logic [3:0] SEL_H0 = 4'b1100;
    localparam logic [3:0] SEL_H1 = 4'b0011;
    localparam logic [3:0] SEL_W  = 4'b1111;

    localparam int DEPTH_DEFAULT = 1024;
    localparam int WAIT_MAX      = 15;
    localparam int CNT_W         = 4;

    // Per-lane write enables: the byte enables pass through only when the write commits.
    function automatic logic [3:0] lane_we(input logic en, input logic [3:0] sel);
        return en ? sel : 4'b0000;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word storage built from four byte-wide arrays.
// Lane g holds bits 8*g+7:8*g of each word.
// Each lane has its own write enable. Read is combinational.
// Contents are not reset.
// Ports:
//   clk    rising-edge clock
//   we     per-lane write enables (lane 3 = bits 31:24)
//   addr   word index
//   wdata  lane-aligned write data
//   rdata  full word at addr
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] lane_mem_r [DEPTH];

        // Byte-lane write on the clock edge.
        always_ff @(posedge clk) begin
            if (we[g]) begin
                lane_mem_r[addr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = lane_mem_r[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage data port.
// Each access takes WAIT_STATES stall cycles, then a completion cycle.
// With WAIT_STATES=0 the access completes in the request cycle.
// Optional feature macro: DMEM_BUS_ERR_EN.
//   With the macro: an out-of-range address or a sel_i=0000 completion raises bus_err_o.
//     The write is dropped and rdata_o is 0.
//   Without the macro: the address wraps modulo DEPTH_WORDS and bus_err_o is tied 0.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   ce_i        request; held stable by the initiator while stall_o=1
//   we_i        1 = write, 0 = read
//   addr_i      byte address; the word index is addr_i[AW+1:2]
//   sel_i       byte enables, big-endian lane order
//   wdata_i     lane-aligned write data
//   rdata_o     read word; 0 unless this cycle completes a read
//   stall_o     access not yet complete
//   bus_err_o   error flag for the completion cycle
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_DEFAULT,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        bus_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // The request cycle in IDLE is the first stall.
    // The counter then holds the number of stall cycles still to come.
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    dmem_state_e      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             stall_s, complete_s, err_s, oor_s, ok_s;
    logic [31:0]      bank_rdata_s;
    logic             unused_s;

    // Next-state, wait counter and completion decode.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        stall_s    = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ce_i) begin
                    if (WAIT_STATES == 0) begin
                        complete_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                        cnt_s   = WAIT_LOAD;
                        state_s = (WAIT_LOAD == {CNT_W{1'b0}}) ? ST_DONE : ST_BUSY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                if (!ce_i) begin
                    // The initiator withdrew the request, so the access aborts.
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r <= CNT_W'(1)) begin
                    state_s = ST_DONE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                complete_s = ce_i;
                state_s    = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    assign oor_s = |(addr_i >> (AW + 2));

`ifdef DMEM_BUS_ERR_EN
    assign err_s = complete_s & (oor_s | (sel_i == 4'b0000));
`else
    assign err_s = 1'b0;
`endif

    // A reset in the completion cycle abandons the access.
    assign ok_s = complete_s & ~rst & ~err_s;

    dmem_bank #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .we    (lane_we(ok_s & we_i, sel_i)),
        .addr  (addr_i[AW+1:2]),
        .wdata (wdata_i),
        .rdata (bank_rdata_s)
    );

    assign rdata_o   = (ok_s & ~we_i) ? bank_rdata_s : 32'h0000_0000;
    assign stall_o   = stall_s & ~rst;
    assign bus_err_o = err_s & ~rst;

    // The byte offset and the high address bits do not select storage.
    // The high bits only feed the optional range check.
    assign unused_s = ^{addr_i[1:0], oor_s};

endmodule
